hsst_lane_rst_seq: RTL



---
 rtl/hsst_rst_pkg.sv | 62 ++++++
 rtl/hsst_lane_rst_seq_if.sv | 30 +++
 rtl/hsst_lock_filter.sv | 50 +++++
 rtl/hsst_lane_rst_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hsst_rst_pkg.sv
// -----------------------------------------------------------------------------
// hsst_rst_pkg
// Shared definitions for the per-lane HSST reset sequencer:
//   - sequencer state encodings (3-bit, codes 6/7 illegal)
//   - default pulse and lock-filter lengths
//   - bundle of registered reset/status outputs and its state decoder
// -----------------------------------------------------------------------------
package hsst_rst_pkg;

    localparam int STATE_W             = 3;
    localparam int RST_PULSE_LEN_DEF   = 16;
    localparam int LOCK_FILTER_LEN_DEF = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST  = 3'd0,
        ST_WAIT_PLL = 3'd1,
        ST_TX_RLS   = 3'd2,
        ST_WAIT_CDR = 3'd3,
        ST_RX_RST   = 3'd4,
        ST_READY    = 3'd5
    } hsst_state_e;

    typedef struct packed {
        logic pll_rst;
        logic lane_pd;
        logic tx_rst;
        logic rx_rst;
        logic ready;
    } hsst_rst_out_t;

    // Output levels held while in a given state. Anything unrecognised maps
    // to the fully-reset pattern so an illegal code can never release a lane.
    function automatic hsst_rst_out_t decode_outputs(input hsst_state_e s);
        hsst_rst_out_t o;
        o.pll_rst = 1'b1;
        o.lane_pd = 1'b1;
        o.tx_rst  = 1'b1;
        o.rx_rst  = 1'b1;
        o.ready   = 1'b0;
        case (s)
            ST_WAIT_PLL: begin
                o.pll_rst = 1'b0;
                o.lane_pd = 1'b0;
            end
            ST_TX_RLS, ST_WAIT_CDR, ST_RX_RST: begin
                o.pll_rst = 1'b0;
                o.lane_pd = 1'b0;
                o.tx_rst  = 1'b0;
            end
            ST_READY: begin
                o.pll_rst = 1'b0;
                o.lane_pd = 1'b0;
                o.tx_rst  = 1'b0;
                o.rx_rst  = 1'b0;
                o.ready   = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/hsst_lane_rst_seq_if.sv
// -----------------------------------------------------------------------------
// hsst_lane_rst_seq_if
// Signals between the reset sequencer and one lane of the HSST hard macro.
//   i_pll_lock / i_cdr_lock / i_sigdet : macro status, asynchronous to clk
//   o_pll_rst / o_lane_pd / o_tx_rst / o_rx_rst : macro reset controls, active high
// Modports:
//   master : sequencer side (reads status, drives resets)
//   slave  : macro side (drives status, reads resets)
// -----------------------------------------------------------------------------
interface hsst_lane_rst_seq_if;

    logic i_pll_lock;
    logic i_cdr_lock;
    logic i_sigdet;
    logic o_pll_rst;
    logic o_lane_pd;
    logic o_tx_rst;
    logic o_rx_rst;

    modport master (
        input  i_pll_lock, i_cdr_lock, i_sigdet,
        output o_pll_rst, o_lane_pd, o_tx_rst, o_rx_rst
    );

    modport slave (
        output i_pll_lock, i_cdr_lock, i_sigdet,
        input  o_pll_rst, o_lane_pd, o_tx_rst, o_rx_rst
    );

endinterface

// File: rtl/hsst_lock_filter.sv
// -----------------------------------------------------------------------------
// hsst_lock_filter
// Two-flop synchronizer followed by a consecutive-high qualifier.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_async      : asynchronous status input from the macro
//   o_synced     : synchronized level (2 cycles of latency)
//   o_filtered   : high once o_synced has been high LOCK_FILTER_LEN
//                  consecutive cycles; falls with the first synced-low cycle
// -----------------------------------------------------------------------------
module hsst_lock_filter
    import hsst_rst_pkg::*;
#(
    parameter int LOCK_FILTER_LEN = LOCK_FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_synced,
    output logic o_filtered
);

    localparam int              CW      = $clog2(LOCK_FILTER_LEN + 1);
    localparam logic [CW-1:0]   LP_FULL = CW'(LOCK_FILTER_LEN - 1);

    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;

    // r_cnt holds how many synced-high cycles preceded the current one,
    // saturating so the filtered output stays high while the lock holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            if (!r_sync)
                r_cnt <= '0;
            else if (r_cnt != LP_FULL)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_synced   = r_sync;
    assign o_filtered = r_sync && (r_cnt == LP_FULL);

endmodule

// File: rtl/hsst_lane_rst_seq.sv
// -----------------------------------------------------------------------------
// hsst_lane_rst_seq
// Per-lane HSST reset sequencer: PLL reset -> wait PLL lock -> release TX ->
// wait CDR lock + signal detect -> lane ready. Retries on timeout and
// re-sequences on lock loss.
// Ports:
//   clk, rst_n   : reference clock, asynchronous active-low reset
//   i_restart    : synchronous restart request (level or pulse)
//   macro_if     : macro status inputs and reset outputs (master modport)
//   o_ready      : lane up
//   o_state      : current state encoding
//   o_retry_cnt  : saturating count of timeouts and lock losses
// -----------------------------------------------------------------------------
module hsst_lane_rst_seq
    import hsst_rst_pkg::*;
#(
    parameter int RST_PULSE_LEN   = RST_PULSE_LEN_DEF,
    parameter int LOCK_FILTER_LEN = LOCK_FILTER_LEN_DEF,
    parameter int PLL_TIMEOUT     = 65536,
    parameter int CDR_TIMEOUT     = 65536,
    parameter int CNT_WIDTH       = 17,
    parameter int RETRY_WIDTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_restart,
    hsst_lane_rst_seq_if.master    macro_if,
    output logic                   o_ready,
    output logic [STATE_W-1:0]     o_state,
    output logic [RETRY_WIDTH-1:0] o_retry_cnt
);

    localparam logic [CNT_WIDTH-1:0] LP_PULSE_END = CNT_WIDTH'(RST_PULSE_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] LP_PLL_TO    = CNT_WIDTH'(PLL_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] LP_CDR_TO    = CNT_WIDTH'(CDR_TIMEOUT - 1);

    logic w_pll_sync, w_pll_filt;
    logic w_cdr_sync, w_cdr_filt;
    logic w_sd_sync,  w_sd_filt;

    hsst_state_e            r_state;
    hsst_state_e            w_next;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [RETRY_WIDTH-1:0] r_retry;
    logic                   r_rx_ok;
    hsst_rst_out_t          r_out;
    logic                   w_retry_inc;
    logic                   w_clr;

    hsst_lock_filter #(.LOCK_FILTER_LEN(LOCK_FILTER_LEN)) u_pll_filt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_async    (macro_if.i_pll_lock),
        .o_synced   (w_pll_sync),
        .o_filtered (w_pll_filt)
    );

    hsst_lock_filter #(.LOCK_FILTER_LEN(LOCK_FILTER_LEN)) u_cdr_filt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_async    (macro_if.i_cdr_lock),
        .o_synced   (w_cdr_sync),
        .o_filtered (w_cdr_filt)
    );

    hsst_lock_filter #(.LOCK_FILTER_LEN(LOCK_FILTER_LEN)) u_sd_filt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_async    (macro_if.i_sigdet),
        .o_synced   (w_sd_sync),
        .o_filtered (w_sd_filt)
    );

    // Next-state logic. The lock-loss and restart overrides are applied last
    // so they win over any in-state timeout or CDR loss in the same cycle;
    // restart is applied after lock loss so it suppresses the retry count.
    always_comb begin
        w_next      = r_state;
        w_retry_inc = 1'b0;
        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == LP_PULSE_END)
                    w_next = ST_WAIT_PLL;
            end
            ST_WAIT_PLL: begin
                if (w_pll_filt) begin
                    w_next = ST_TX_RLS;
                end else if (r_cnt == LP_PLL_TO) begin
                    w_next      = ST_PLL_RST;
                    w_retry_inc = 1'b1;
                end
            end
            ST_TX_RLS: begin
                w_next = ST_WAIT_CDR;
            end
            ST_WAIT_CDR: begin
                if (r_rx_ok) begin
                    w_next = ST_READY;
                end else if (r_cnt == LP_CDR_TO) begin
                    w_next      = ST_RX_RST;
                    w_retry_inc = 1'b1;
                end
            end
            ST_RX_RST: begin
                if (r_cnt == LP_PULSE_END)
                    w_next = ST_WAIT_CDR;
            end
            ST_READY: begin
                if (!w_cdr_sync || !w_sd_sync) begin
                    w_next      = ST_WAIT_CDR;
                    w_retry_inc = 1'b1;
                end
            end
            default: begin
                w_next = ST_PLL_RST;
            end
        endcase

        if ((r_state inside {ST_TX_RLS, ST_WAIT_CDR, ST_RX_RST, ST_READY}) && !w_pll_sync) begin
            w_next      = ST_PLL_RST;
            w_retry_inc = 1'b1;
        end

        if (i_restart) begin
            w_next      = ST_PLL_RST;
            w_retry_inc = 1'b0;
        end
    end

    // A held restart re-enters PLL_RST every cycle, so it also clears the timer.
    assign w_clr = (w_next != r_state) || i_restart;

    // The timer is free to wrap while parked in READY; no compare is active there.
    // r_rx_ok registers the combined CDR/sigdet qualification so the two
    // filter outputs meet at a flop before feeding the state decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PLL_RST;
            r_cnt   <= '0;
            r_retry <= '0;
            r_rx_ok <= 1'b0;
            r_out   <= decode_outputs(ST_PLL_RST);
        end else begin
            r_state <= w_next;
            r_cnt   <= w_clr ? '0 : r_cnt + 1'b1;
            r_rx_ok <= w_cdr_filt && w_sd_filt;
            r_out   <= decode_outputs(w_next);
            if (w_retry_inc && (r_retry != '1))
                r_retry <= r_retry + 1'b1;
        end
    end

    assign macro_if.o_pll_rst = r_out.pll_rst;
    assign macro_if.o_lane_pd = r_out.lane_pd;
    assign macro_if.o_tx_rst  = r_out.tx_rst;
    assign macro_if.o_rx_rst  = r_out.rx_rst;
    assign o_ready            = r_out.ready;
    assign o_state            = r_state;
    assign o_retry_cnt        = r_retry;

endmodule
